// File: rtl/icache_assoc.sv
// icache_assoc: N-way set-associative instruction cache with VIPT lookup,
// one outstanding request, whole-line refill and per-set round-robin victims.
// Optional feature macro: ICACHE_PERF_CNT_EN adds hit_count/miss_count outputs.
module icache_assoc #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WAY_NUM    = 2,
  parameter int SET_NUM    = 256,
  parameter int LINE_WORDS = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cpu_icache_read_en,
  input  logic [ADDR_WIDTH-1:0]            virtual_addr,
  input  logic [ADDR_WIDTH-1:0]            physical_addr,
  input  logic                             cpu_receive_data_ok,
  output logic                             cpu_icache_addr_request_ok,
  output logic                             icache_cpu_return_data_en,
  output logic [DATA_WIDTH-1:0]            icache_cpu_return_data,
  output logic                             icache_mem_read_request,
  output logic [ADDR_WIDTH-1:0]            icache_mem_read_addr,
  input  logic                             mem_ready_to_read,
  input  logic                             mem_read_addr_ok,
  input  logic                             mem_return_en,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] mem_return_data,
  output logic                             read_data_from_mem_ok,
`ifdef ICACHE_PERF_CNT_EN
  output logic [31:0]                      hit_count,
  output logic [31:0]                      miss_count,
`endif
  output logic                             cache_hit_fail_output
);

  localparam int INDEX_SIZE  = $clog2(SET_NUM);
  localparam int OFFSET_SIZE = $clog2(LINE_WORDS * (DATA_WIDTH / 8));
  localparam int TAG_SIZE    = ADDR_WIDTH - INDEX_SIZE - OFFSET_SIZE;
  localparam int WORD_W      = $clog2(LINE_WORDS);
  localparam int BYTE_OFF    = OFFSET_SIZE - WORD_W;
  localparam int LINE_W      = LINE_WORDS * DATA_WIDTH;
  localparam int WAY_W       = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MISS_REQ, S_REFILL, S_RESPOND} state_t;

  state_t                  state_q, state_d;
  logic [INDEX_SIZE-1:0]   index_q, index_d;
  logic [WORD_W-1:0]       word_q, word_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic [WAY_NUM-1:0]      valid_q [SET_NUM];
  logic [WAY_W-1:0]        rr_q    [SET_NUM];
  logic [TAG_SIZE-1:0]     tag_q   [WAY_NUM][SET_NUM];
  logic [LINE_W-1:0]       line_q  [WAY_NUM][SET_NUM];

  logic [TAG_SIZE-1:0]     ptag;
  logic                    hit;
  logic [WAY_W-1:0]        hit_way;
  logic [WAY_W-1:0]        victim;
  logic                    set_full;
  logic [WAY_W-1:0]        rr_next;
  logic                    fill;
  logic                    addr_ok;
  logic                    mem_req;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   hit_word;
  logic [DATA_WIDTH-1:0]   ret_word;
  logic                    unused_addr_bits;

  // Address bits that take no part in indexing, tagging or word selection.
  assign unused_addr_bits = ^{virtual_addr[BYTE_OFF-1:0],
                              virtual_addr[ADDR_WIDTH-1:OFFSET_SIZE+INDEX_SIZE],
                              physical_addr[ADDR_WIDTH-TAG_SIZE-1:0]};

  assign ptag     = physical_addr[ADDR_WIDTH-1 -: TAG_SIZE];
  assign hit_word = line_q[hit_way][index_q][word_q*DATA_WIDTH +: DATA_WIDTH];
  assign ret_word = mem_return_data[word_q*DATA_WIDTH +: DATA_WIDTH];
  assign rr_next  = (rr_q[index_q] == WAY_W'(WAY_NUM - 1)) ? '0 : rr_q[index_q] + 1'b1;

  // Tag compare across all ways of the latched set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAY_NUM; w++) begin
      if (valid_q[index_q][w] && (tag_q[w][index_q] == ptag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim: lowest invalid way, otherwise the set's round-robin pointer.
  always_comb begin
    victim   = rr_q[index_q];
    set_full = 1'b1;
    for (int w = WAY_NUM - 1; w >= 0; w--) begin
      if (!valid_q[index_q][w]) begin
        victim   = WAY_W'(w);
        set_full = 1'b0;
      end
    end
  end

  // Next-state and output decode of the request FSM.
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    word_d   = word_q;
    rdata_d  = rdata_q;
    addr_ok  = 1'b0;
    mem_req  = 1'b0;
    mem_addr = '0;
    fill     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_icache_read_en) begin
          addr_ok = 1'b1;
          index_d = virtual_addr[OFFSET_SIZE +: INDEX_SIZE];
          word_d  = virtual_addr[BYTE_OFF +: WORD_W];
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          rdata_d = hit_word;
          state_d = S_RESPOND;
        end else begin
          state_d = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        if (mem_ready_to_read) begin
          mem_req  = 1'b1;
          mem_addr = {ptag, index_q, {OFFSET_SIZE{1'b0}}};
          if (mem_read_addr_ok) begin
            if (mem_return_en) begin
              fill    = 1'b1;
              rdata_d = ret_word;
              state_d = S_RESPOND;
            end else begin
              state_d = S_REFILL;
            end
          end
        end
      end
      S_REFILL: begin
        if (mem_return_en) begin
          fill    = 1'b1;
          rdata_d = ret_word;
          state_d = S_RESPOND;
        end
      end
      S_RESPOND: begin
        if (cpu_receive_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A cycle with reset asserted must neither handshake nor write the arrays.
    if (reset) begin
      addr_ok  = 1'b0;
      mem_req  = 1'b0;
      mem_addr = '0;
      fill     = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Request context and response word; no reset needed, qualified by FSM state.
  always_ff @(posedge clk) begin
    index_q <= index_d;
    word_q  <= word_d;
    rdata_q <= rdata_d;
  end

  // Valid bits and round-robin pointers, cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SET_NUM; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (fill) begin
      valid_q[index_q][victim] <= 1'b1;
      if (set_full) rr_q[index_q] <= rr_next;
    end
  end

  // Tag and line storage written on refill capture.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[victim][index_q]  <= ptag;
      line_q[victim][index_q] <= mem_return_data;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  // Lookup outcome counters, wrapping naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state_q == S_LOOKUP) begin
      if (hit) hit_count  <= hit_count + 32'd1;
      else     miss_count <= miss_count + 32'd1;
    end
  end
`endif

  assign cpu_icache_addr_request_ok = addr_ok;
  assign icache_cpu_return_data_en  = (state_q == S_RESPOND);
  assign icache_cpu_return_data     = (state_q == S_RESPOND) ? rdata_q : '0;
  assign icache_mem_read_request    = mem_req;
  assign icache_mem_read_addr       = mem_addr;
  assign read_data_from_mem_ok      = fill;
  assign cache_hit_fail_output      = (state_q == S_MISS_REQ) || (state_q == S_REFILL);

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: miss/hit paths, eviction, bridge stalls,
// reset during refill and, when ICACHE_PERF_CNT_EN is defined, the counters.
module tb_icache_assoc;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cpu_icache_read_en = 1'b0;
  logic [31:0]  virtual_addr = '0;
  logic [31:0]  physical_addr = '0;
  logic         cpu_receive_data_ok = 1'b0;
  logic         cpu_icache_addr_request_ok;
  logic         icache_cpu_return_data_en;
  logic [31:0]  icache_cpu_return_data;
  logic         icache_mem_read_request;
  logic [31:0]  icache_mem_read_addr;
  logic         mem_ready_to_read = 1'b1;
  logic         mem_read_addr_ok = 1'b0;
  logic         mem_return_en = 1'b0;
  logic [255:0] mem_return_data = '0;
  logic         read_data_from_mem_ok;
  logic         cache_hit_fail_output;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  icache_assoc dut (
    .clk                        (clk),
    .reset                      (reset),
    .cpu_icache_read_en         (cpu_icache_read_en),
    .virtual_addr               (virtual_addr),
    .physical_addr              (physical_addr),
    .cpu_receive_data_ok        (cpu_receive_data_ok),
    .cpu_icache_addr_request_ok (cpu_icache_addr_request_ok),
    .icache_cpu_return_data_en  (icache_cpu_return_data_en),
    .icache_cpu_return_data     (icache_cpu_return_data),
    .icache_mem_read_request    (icache_mem_read_request),
    .icache_mem_read_addr       (icache_mem_read_addr),
    .mem_ready_to_read          (mem_ready_to_read),
    .mem_read_addr_ok           (mem_read_addr_ok),
    .mem_return_en              (mem_return_en),
    .mem_return_data            (mem_return_data),
    .read_data_from_mem_ok      (read_data_from_mem_ok),
`ifdef ICACHE_PERF_CNT_EN
    .hit_count                  (hit_count),
    .miss_count                 (miss_count),
`endif
    .cache_hit_fail_output      (cache_hit_fail_output)
  );

  always #5 clk = ~clk;

  // Line whose word i holds base + i.
  function automatic logic [255:0] make_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  // One fetch from request to CPU consumption, serving memory when asked.
  task automatic run_fetch(input logic [31:0] va, input logic [31:0] pa, input logic [255:0] line,
                           input bit same_cycle, output logic [31:0] data, output bit got,
                           output bit accepted, output int lat, output int n_req,
                           output logic [31:0] req_addr, output bit saw_fail, output int pulses);
    bit addr_sent;
    bit returned;
    got = 0; lat = 0; n_req = 0; req_addr = '0; saw_fail = 0; pulses = 0; data = '0;
    addr_sent = 0; returned = 0;
    virtual_addr = va; physical_addr = pa; cpu_icache_read_en = 1'b1;
    #1;
    accepted = cpu_icache_addr_request_ok;
    @(posedge clk); #1;
    cpu_icache_read_en = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (icache_cpu_return_data_en) begin
        data = icache_cpu_return_data; lat = i + 1; got = 1; cpu_receive_data_ok = 1'b1;
      end else begin
        if (cache_hit_fail_output) saw_fail = 1;
        if (icache_mem_read_request) begin n_req++; req_addr = icache_mem_read_addr; end
        if (icache_mem_read_request && !addr_sent) begin
          mem_read_addr_ok = 1'b1; addr_sent = 1;
          if (same_cycle) begin mem_return_en = 1'b1; mem_return_data = line; returned = 1; end
        end else if (addr_sent && !returned) begin
          mem_return_en = 1'b1; mem_return_data = line; returned = 1;
        end
      end
      #1;
      if (read_data_from_mem_ok) pulses++;
      @(posedge clk); #1;
      mem_read_addr_ok = 1'b0; mem_return_en = 1'b0; mem_return_data = '0; cpu_receive_data_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (icache_cpu_return_data_en !== 1'b0 || icache_mem_read_request !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_reset: data_en=%b mem_req=%b, required 0/0",
                         icache_cpu_return_data_en, icache_mem_read_request);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({cpu_icache_addr_request_ok, icache_cpu_return_data_en, icache_mem_read_request,
         read_data_from_mem_ok, cache_hit_fail_output} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b, required 00000",
                         {cpu_icache_addr_request_ok, icache_cpu_return_data_en, icache_mem_read_request,
                          read_data_from_mem_ok, cache_hit_fail_output});
    end
    n_checks++;
    if (icache_cpu_return_data !== 32'h0 || icache_mem_read_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_buses: data=%h addr=%h, required 0/0",
                         icache_cpu_return_data, icache_mem_read_addr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_miss();
    logic [31:0] d, ra; bit got, acc, sf; int lat, nr, pl;
    run_fetch(32'h8000_0000, 32'h8000_0000, make_line(32'h1000_0000), 1'b0,
              d, got, acc, lat, nr, ra, sf, pl);
    n_checks++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL miss_accept: got %b, required 1", acc); end
    n_checks++;
    if (nr != 1 || ra !== 32'h8000_0000) begin
      n_fail++; $display("FAIL miss_req: count=%0d addr=%h, required 1/80000000", nr, ra);
    end
    n_checks++;
    if (!got || d !== 32'h1000_0000) begin
      n_fail++; $display("FAIL miss_data: got=%b data=%h, required 1/10000000", got, d);
    end
    n_checks++;
    if (sf !== 1'b1) begin n_fail++; $display("FAIL miss_hitfail: got %b, required 1", sf); end
    n_checks++;
    if (pl != 1) begin n_fail++; $display("FAIL miss_pulse: got %0d, required 1", pl); end
    n_checks++;
    if (cache_hit_fail_output !== 1'b0) begin
      n_fail++; $display("FAIL miss_hitfail_after: got %b, required 0", cache_hit_fail_output);
    end
  endtask

  task automatic test_hit();
    logic [31:0] d, ra; bit got, acc, sf; int lat, nr, pl;
    run_fetch(32'h8000_0000, 32'h8000_0000, '0, 1'b0, d, got, acc, lat, nr, ra, sf, pl);
    n_checks++;
    if (!got || d !== 32'h1000_0000 || lat != 2) begin
      n_fail++; $display("FAIL hit_word0: got=%b data=%h lat=%0d, required 1/10000000/2", got, d, lat);
    end
    n_checks++;
    if (nr != 0 || sf !== 1'b0 || pl != 0) begin
      n_fail++; $display("FAIL hit0_nomem: req=%0d hitfail=%b pulses=%0d, required 0/0/0", nr, sf, pl);
    end
    run_fetch(32'h8000_001C, 32'h8000_001C, '0, 1'b0, d, got, acc, lat, nr, ra, sf, pl);
    n_checks++;
    if (!got || d !== 32'h1000_0007 || lat != 2) begin
      n_fail++; $display("FAIL hit_word7: got=%b data=%h lat=%0d, required 1/10000007/2", got, d, lat);
    end
    n_checks++;
    if (nr != 0) begin n_fail++; $display("FAIL hit7_nomem: req=%0d, required 0", nr); end
  endtask

  task automatic test_evict();
    logic [31:0] d, ra; bit got, acc, sf; int lat, nr, pl;
    run_fetch(32'h8001_0000, 32'h8001_0000, make_line(32'h2000_0000), 1'b0, d, got, acc, lat, nr, ra, sf, pl);
    n_checks++;
    if (nr != 1 || !got || d !== 32'h2000_0000) begin
      n_fail++; $display("FAIL evict_fill1: req=%0d data=%h, required 1/20000000", nr, d);
    end
    run_fetch(32'h8002_0000, 32'h8002_0000, make_line(32'h3000_0000), 1'b0, d, got, acc, lat, nr, ra, sf, pl);
    n_checks++;
    if (nr != 1 || ra !== 32'h8002_0000 || !got || d !== 32'h3000_0000) begin
      n_fail++; $display("FAIL evict_fill2: req=%0d addr=%h data=%h, required 1/80020000/30000000", nr, ra, d);
    end
    run_fetch(32'h8001_0004, 32'h8001_0004, '0, 1'b0, d, got, acc, lat, nr, ra, sf, pl);
    n_checks++;
    if (nr != 0 || !got || d !== 32'h2000_0001) begin
      n_fail++; $display("FAIL evict_way1_kept: req=%0d data=%h, required 0/20000001", nr, d);
    end
    run_fetch(32'h8000_0000, 32'h8000_0000, make_line(32'h1000_0000), 1'b0, d, got, acc, lat, nr, ra, sf, pl);
    n_checks++;
    if (nr != 1 || ra !== 32'h8000_0000 || d !== 32'h1000_0000) begin
      n_fail++; $display("FAIL evict_way0_gone: req=%0d addr=%h data=%h, required 1/80000000/10000000", nr, ra, d);
    end
    run_fetch(32'h8002_0008, 32'h8002_0008, '0, 1'b0, d, got, acc, lat, nr, ra, sf, pl);
    n_checks++;
    if (nr != 0 || d !== 32'h3000_0002) begin
      n_fail++; $display("FAIL evict_rr_way0_kept: req=%0d data=%h, required 0/30000002", nr, d);
    end
    run_fetch(32'h8001_0000, 32'h8001_0000, make_line(32'h2000_0000), 1'b0, d, got, acc, lat, nr, ra, sf, pl);
    n_checks++;
    if (nr != 1) begin n_fail++; $display("FAIL evict_rr_way1_gone: req=%0d, required 1", nr); end
  endtask

  task automatic test_bridge();
    int bad;
    int pulses;
    bad = 0; pulses = 0;
    mem_ready_to_read = 1'b0;
    virtual_addr = 32'h8000_0048; physical_addr = 32'h8000_0048; cpu_icache_read_en = 1'b1;
    @(posedge clk); #1;
    cpu_icache_read_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (icache_mem_read_request !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (bad != 0 || cache_hit_fail_output !== 1'b1) begin
      n_fail++; $display("FAIL bridge_stall: req_cycles=%0d hitfail=%b, required 0/1", bad, cache_hit_fail_output);
    end
    mem_ready_to_read = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      if (icache_mem_read_request !== 1'b1 || icache_mem_read_addr !== 32'h8000_0040) bad++;
      if (read_data_from_mem_ok) pulses++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL bridge_hold: unstable_cycles=%0d, required 0", bad); end
    mem_read_addr_ok = 1'b1; mem_return_en = 1'b1; mem_return_data = make_line(32'h4000_0000);
    #1;
    if (read_data_from_mem_ok) pulses++;
    @(posedge clk); #1;
    mem_read_addr_ok = 1'b0; mem_return_en = 1'b0; mem_return_data = '0;
    n_checks++;
    if (icache_cpu_return_data_en !== 1'b1 || icache_cpu_return_data !== 32'h4000_0002) begin
      n_fail++; $display("FAIL bridge_data: en=%b data=%h, required 1/40000002",
                         icache_cpu_return_data_en, icache_cpu_return_data);
    end
    if (read_data_from_mem_ok) pulses++;
    n_checks++;
    if (pulses != 1 || cache_hit_fail_output !== 1'b0) begin
      n_fail++; $display("FAIL bridge_pulse: pulses=%0d hitfail=%b, required 1/0", pulses, cache_hit_fail_output);
    end
    cpu_receive_data_ok = 1'b1;
    @(posedge clk); #1;
    cpu_receive_data_ok = 1'b0;
    n_checks++;
    if (icache_cpu_return_data_en !== 1'b0) begin
      n_fail++; $display("FAIL bridge_release: en=%b, required 0", icache_cpu_return_data_en);
    end
  endtask

  task automatic test_reset_refill();
    logic [31:0] d, ra; bit got, acc, sf; int lat, nr, pl; bit seen;
    seen = 0;
    virtual_addr = 32'h8000_0080; physical_addr = 32'h8000_0080; cpu_icache_read_en = 1'b1;
    @(posedge clk); #1;
    cpu_icache_read_en = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (icache_mem_read_request) begin seen = 1; mem_read_addr_ok = 1'b1; end
      @(posedge clk); #1;
    end
    mem_read_addr_ok = 1'b0;
    n_checks++;
    if (!seen || cache_hit_fail_output !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_refill: req_seen=%b hitfail=%b, required 1/1", seen, cache_hit_fail_output);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if ({icache_cpu_return_data_en, icache_mem_read_request, read_data_from_mem_ok,
         cache_hit_fail_output} !== 4'b0 || icache_cpu_return_data !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_outputs: flags=%b data=%h, required 0000/0",
                         {icache_cpu_return_data_en, icache_mem_read_request, read_data_from_mem_ok,
                          cache_hit_fail_output}, icache_cpu_return_data);
    end
    mem_return_en = 1'b1; mem_return_data = make_line(32'h5000_0000);
    #1;
    n_checks++;
    if (read_data_from_mem_ok !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_late_return: pulse=%b, required 0", read_data_from_mem_ok);
    end
    @(posedge clk); #1;
    mem_return_en = 1'b0; mem_return_data = '0;
    n_checks++;
    if (icache_cpu_return_data_en !== 1'b0 || cache_hit_fail_output !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_idle: en=%b hitfail=%b, required 0/0",
                         icache_cpu_return_data_en, cache_hit_fail_output);
    end
    run_fetch(32'h8000_0080, 32'h8000_0080, make_line(32'h6000_0000), 1'b1, d, got, acc, lat, nr, ra, sf, pl);
    n_checks++;
    if (nr != 1 || ra !== 32'h8000_0080 || d !== 32'h6000_0000 || pl != 1) begin
      n_fail++; $display("FAIL rstmid_reread: req=%0d addr=%h data=%h pulses=%0d, required 1/80000080/60000000/1",
                         nr, ra, d, pl);
    end
    run_fetch(32'h8000_0048, 32'h8000_0048, make_line(32'h4000_0000), 1'b0, d, got, acc, lat, nr, ra, sf, pl);
    n_checks++;
    if (nr != 1 || d !== 32'h4000_0002) begin
      n_fail++; $display("FAIL rstmid_valids_cleared: req=%0d data=%h, required 1/40000002", nr, d);
    end
  endtask

`ifdef ICACHE_PERF_CNT_EN
  task automatic test_perf_cnt();
    logic [31:0] d, ra; bit got, acc, sf; int lat, nr, pl;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      n_fail++; $display("FAIL perf_reset: hit=%0d miss=%0d, required 0/0", hit_count, miss_count);
    end
    run_fetch(32'h8000_0000, 32'h8000_0000, make_line(32'h1000_0000), 1'b0, d, got, acc, lat, nr, ra, sf, pl);
    run_fetch(32'h8000_0000, 32'h8000_0000, '0, 1'b0, d, got, acc, lat, nr, ra, sf, pl);
    run_fetch(32'h8000_001C, 32'h8000_001C, '0, 1'b0, d, got, acc, lat, nr, ra, sf, pl);
    n_checks++;
    if (hit_count !== 32'd2 || miss_count !== 32'd1) begin
      n_fail++; $display("FAIL perf_counts: hit=%0d miss=%0d, required 2/1", hit_count, miss_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_miss();
    test_hit();
    test_evict();
    test_bridge();
    test_reset_refill();
`ifdef ICACHE_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
